c7bcsr_tctl: RTL and testbench
==============================

Name: c7bcsr_tctl

Overview:
- Software-facing control end of the CSR timer.
- Holds the TCFG register and issues the one-cycle init strobe to the timer core.
- Captures the timer's one-cycle interrupt pulse into a sticky pending bit, cleared through TICLR writes.
- Exposes TCFG, TVAL and TICLR on the CSR read/write bus. Drives the timer-interrupt pending bit (ESTAT.IS[11]) and a masked interrupt request to the core.

Parameters:
- TIMER_BIT, 30, InitVal width; TCFG[31:2] = InitVal, counter width TIMER_BIT+2.
- TCFG_ADDR, 14'h041, CSR number of TCFG.
- TVAL_ADDR, 14'h042, CSR number of TVAL.
- TICLR_ADDR, 14'h044, CSR number of TICLR.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- csr_we  in  1  CSR write strobe
- csr_waddr  in  14  write CSR number
- csr_wdata  in  32  write data
- csr_raddr  in  14  read CSR number
- csr_rdata  out  32  read data, combinational
- csr_rhit  out  1  csr_raddr matches one of the three CSRs
- timer_init  out  1  init strobe to timer core
- timer_en  out  1  TCFG.En
- timer_periodic  out  1  TCFG.Periodic
- timer_initval  out  TIMER_BIT  TCFG.InitVal
- timer_val  in  TIMER_BIT+2  live counter from timer core
- timer_intr  in  1  one-cycle expiry pulse from timer core
- lie_ti  in  1  ECFG.LIE timer enable
- ti_pending  out  1  ESTAT.IS[11]
- ti_ovf  out  1  expiry occurred while already pending (sticky)
- irq_ti  out  1  registered ti_pending & lie_ti

Behaviour:
- Reset (resetn=0 at a clk edge): TCFG=0, timer_init=0, ti_pending=0, ti_ovf=0, irq_ti=0, state=IDLE. Reset mid-operation aborts any pending init strobe.

TCFG write (csr_we & csr_waddr==TCFG_ADDR):
- Next edge: En=wdata[0], Periodic=wdata[1], InitVal=wdata[31:2].
- timer_init is registered. It is 1 for exactly the one cycle after the TCFG write cycle, so it coincides with the new En value. The timer therefore loads {InitVal,2'b0} on the following edge.
- Back-to-back TCFG writes: each write produces its own strobe. The last write's values win.

State machine (tracks the arm sequence):
- IDLE: En=0.
- ARM: the cycle timer_init=1.
- RUN: En=1 and armed.
- Transitions:
  - IDLE->ARM on a TCFG write with wdata[0]=1.
  - RUN->ARM on a TCFG write with wdata[0]=1.
  - ARM->RUN unconditionally.
  - Any state->IDLE on a TCFG write with wdata[0]=0.
  - RUN->IDLE when timer_intr=1 and Periodic=0 (one-shot expired). En stays 1 in TCFG; the timer counter wraps and no further intr occurs.
- timer_intr is accepted only in RUN. A pulse in IDLE/ARM is ignored: no pending set.

Pending/clear:
- ti_pending sets on an accepted timer_intr.
- ti_pending clears on a TICLR write with wdata[0]=1.
- Same-cycle set and clear: set wins, pending stays 1.
- ti_ovf sets when an accepted timer_intr arrives while ti_pending=1 and no clear is in that cycle. It is cleared by a TICLR write with wdata[1]=1. ti_ovf is not self-clearing.

irq_ti = ti_pending & lie_ti, registered, one cycle after ti_pending.

Reads (csr_raddr):
- TCFG_ADDR: {InitVal,Periodic,En}.
- TVAL_ADDR: zero-extended timer_val[TIMER_BIT+1:0], live with no latency.
- TICLR_ADDR: {30'b0,ti_ovf,1'b0}. Bit0 always reads 0.
- Any other address: csr_rdata=0 and csr_rhit=0.
- A read of TCFG in the write cycle returns the old value.

Writes to TVAL are ignored.

Test Plan:
- TCFG write 0x0000_0029 (InitVal=10, En=1, one-shot) -> timer_init=1 exactly one cycle later, timer_en=1. After countdown, ti_pending=1. A second expiry never occurs. State returns to IDLE.
- Periodic TCFG 0x0000_0013 (InitVal=4, Per=1, En=1), lie_ti=1, no clears -> first intr sets pending. Second intr sets ti_ovf=1. irq_ti follows pending by 1 cycle.
- TICLR write 0x1 in the same cycle as timer_intr -> ti_pending remains 1. TICLR 0x3 in a quiet cycle -> ti_pending=0, ti_ovf=0.
- TCFG write with En=0 while running -> state IDLE. A forced timer_intr pulse is ignored; ti_pending stays 0.
- Reads: TCFG returns the last written value. TVAL tracks timer_val. TICLR bit0=0. Address 14'h043 -> rdata=0, rhit=0.
- resetn=0 while in ARM with pending=1 -> next cycle all outputs 0, timer_init not issued.

Source files
------------

// File: rtl/c7bcsr_tctl.sv
// CSR-side control for the timer: holds TCFG, strobes the timer core on every
// TCFG write, and turns expiry pulses into a sticky pending bit plus interrupt request.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | timer disabled, or one-shot already expired
// ARM   | init strobe cycle, counter is being loaded
// RUN   | enabled and armed, expiry pulses are accepted
module c7bcsr_tctl #(
    parameter int          TIMER_BIT  = 30,
    parameter logic [13:0] TCFG_ADDR  = 14'h041,
    parameter logic [13:0] TVAL_ADDR  = 14'h042,
    parameter logic [13:0] TICLR_ADDR = 14'h044
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   csr_we,
    input  logic [13:0]            csr_waddr,
    input  logic [31:0]            csr_wdata,
    input  logic [13:0]            csr_raddr,
    output logic [31:0]            csr_rdata,
    output logic                   csr_rhit,
    output logic                   timer_init,
    output logic                   timer_en,
    output logic                   timer_periodic,
    output logic [TIMER_BIT-1:0]   timer_initval,
    input  logic [TIMER_BIT+1:0]   timer_val,
    input  logic                   timer_intr,
    input  logic                   lie_ti,
    output logic                   ti_pending,
    output logic                   ti_ovf,
    output logic                   irq_ti
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic tcfg_we;
    logic ticlr_we;
    logic ti_accept;
    logic ti_clr;
    logic ovf_clr;

    assign tcfg_we  = csr_we && (csr_waddr == TCFG_ADDR);
    assign ticlr_we = csr_we && (csr_waddr == TICLR_ADDR);
    assign ti_clr   = ticlr_we && csr_wdata[0];
    assign ovf_clr  = ticlr_we && csr_wdata[1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A TCFG write overrides everything else, including an expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        if (tcfg_we) begin
            state_nxt = csr_wdata[0] ? S_ARM : S_IDLE;
        end else begin
            case (state)
                S_ARM:   state_nxt = S_RUN;
                S_RUN:   if (timer_intr && !timer_periodic) state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        ti_accept = 1'b0;
        if (state == S_RUN) begin
            ti_accept = timer_intr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer_en       <= 1'b0;
            timer_periodic <= 1'b0;
            timer_initval  <= '0;
            timer_init     <= 1'b0;
        end else begin
            timer_init <= tcfg_we;
            if (tcfg_we) begin
                timer_en       <= csr_wdata[0];
                timer_periodic <= csr_wdata[1];
                timer_initval  <= csr_wdata[TIMER_BIT+1:2];
            end
        end
    end

    // Setting wins over clearing so an expiry racing a clear is never lost.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ti_pending <= 1'b0;
            ti_ovf     <= 1'b0;
            irq_ti     <= 1'b0;
        end else begin
            irq_ti <= ti_pending & lie_ti;
            if (ti_accept) begin
                ti_pending <= 1'b1;
            end else if (ti_clr) begin
                ti_pending <= 1'b0;
            end
            if (ti_accept && ti_pending && !ti_clr) begin
                ti_ovf <= 1'b1;
            end else if (ovf_clr) begin
                ti_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        csr_rhit  = 1'b0;
        case (csr_raddr)
            TCFG_ADDR: begin
                csr_rdata = 32'({timer_initval, timer_periodic, timer_en});
                csr_rhit  = 1'b1;
            end
            TVAL_ADDR: begin
                csr_rdata = 32'(timer_val);
                csr_rhit  = 1'b1;
            end
            TICLR_ADDR: begin
                csr_rdata = {30'b0, ti_ovf, 1'b0};
                csr_rhit  = 1'b1;
            end
            default: begin
                csr_rdata = 32'h0;
                csr_rhit  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_c7bcsr_tctl.sv
// Bench for c7bcsr_tctl: directed scenarios plus a randomized run, all checked
// against a cycle-level reference model of the CSR timer control rules.
module tb_c7bcsr_tctl;

    localparam int TB = 30;
    localparam logic [13:0] A_TCFG  = 14'h041;
    localparam logic [13:0] A_TVAL  = 14'h042;
    localparam logic [13:0] A_NONE  = 14'h043;
    localparam logic [13:0] A_TICLR = 14'h044;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          csr_we = 1'b0;
    logic [13:0]   csr_waddr = '0;
    logic [31:0]   csr_wdata = '0;
    logic [13:0]   csr_raddr = '0;
    logic [31:0]   csr_rdata;
    logic          csr_rhit;
    logic          timer_init;
    logic          timer_en;
    logic          timer_periodic;
    logic [TB-1:0] timer_initval;
    logic [TB+1:0] timer_val = '0;
    logic          timer_intr = 1'b0;
    logic          lie_ti = 1'b0;
    logic          ti_pending;
    logic          ti_ovf;
    logic          irq_ti;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "armed" means the last TCFG write enabled the timer, its
    // strobe cycle has passed, and no one-shot expiry has been taken since.
    logic          m_en, m_per, m_init, m_pend, m_ovf, m_irq, m_done;
    logic [TB-1:0] m_iv;
    int            m_since;

    c7bcsr_tctl dut (
        .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_rhit(csr_rhit), .timer_init(timer_init), .timer_en(timer_en),
        .timer_periodic(timer_periodic), .timer_initval(timer_initval),
        .timer_val(timer_val), .timer_intr(timer_intr), .lie_ti(lie_ti),
        .ti_pending(ti_pending), .ti_ovf(ti_ovf), .irq_ti(irq_ti)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic tw, cw, acc, clr;
        @(posedge clk);
        tw = csr_we && (csr_waddr == A_TCFG);
        cw = csr_we && (csr_waddr == A_TICLR);
        if (!resetn) begin
            m_en = 0; m_per = 0; m_iv = '0; m_init = 0;
            m_pend = 0; m_ovf = 0; m_irq = 0; m_done = 0; m_since = 0;
        end else begin
            acc = timer_intr && m_en && (m_since >= 1) && !m_done;
            clr = cw && csr_wdata[0];
            m_irq = m_pend && lie_ti;
            if (acc && m_pend && !clr) m_ovf = 1;
            else if (cw && csr_wdata[1]) m_ovf = 0;
            if (acc) m_pend = 1;
            else if (clr) m_pend = 0;
            m_init = tw;
            if (acc && !m_per) m_done = 1;
            if (tw) begin
                m_en = csr_wdata[0];
                m_per = csr_wdata[1];
                m_iv = csr_wdata[31:2];
                m_since = 0;
                m_done = 0;
            end else if (m_since < 3) begin
                m_since++;
            end
        end
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_we = 1; csr_waddr = a; csr_wdata = d;
        tick();
        csr_we = 0; csr_waddr = '0; csr_wdata = '0;
    endtask

    task automatic pulse_intr();
        timer_intr = 1;
        tick();
        timer_intr = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        tick(); tick();
        resetn = 1;
        n_tests++;
        if ({timer_init, timer_en, timer_periodic, timer_initval, ti_pending, ti_ovf, irq_ti} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got init=%b en=%b per=%b iv=%h pend=%b ovf=%b irq=%b want all 0",
                     timer_init, timer_en, timer_periodic, timer_initval, ti_pending, ti_ovf, irq_ti);
        end
    endtask

    task automatic test_oneshot();
        wr(A_TCFG, 32'h0000_0029);
        n_tests++;
        if (timer_init !== 1'b1 || timer_en !== 1'b1 || timer_initval !== 30'd10 || timer_periodic !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_strobe got init=%b en=%b iv=%0d per=%b want 1 1 10 0",
                     timer_init, timer_en, timer_initval, timer_periodic);
        end
        tick();
        n_tests++;
        if (timer_init !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_strobe_width got init=%b want 0", timer_init);
        end
        timer_val = 32'd40;
        for (int i = 0; i < 40; i++) begin
            tick();
            timer_val = timer_val - 1;
        end
        pulse_intr();
        n_tests++;
        if (ti_pending !== 1'b1 || ti_ovf !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_expire got pend=%b ovf=%b want 1 0", ti_pending, ti_ovf);
        end
        for (int i = 0; i < 5; i++) tick();
        pulse_intr();
        csr_raddr = A_TCFG;
        #1;
        n_tests++;
        if (ti_pending !== 1'b1 || ti_ovf !== 1'b0 || csr_rdata !== 32'h0000_0029) begin
            n_fail++;
            $display("FAIL oneshot_no_rearm got pend=%b ovf=%b tcfg=%h want 1 0 00000029",
                     ti_pending, ti_ovf, csr_rdata);
        end
    endtask

    task automatic test_periodic();
        wr(A_TICLR, 32'h3);
        lie_ti = 1;
        wr(A_TCFG, 32'h0000_0013);
        tick();
        for (int i = 0; i < 16; i++) tick();
        pulse_intr();
        n_tests++;
        if (ti_pending !== 1'b1 || ti_ovf !== 1'b0 || irq_ti !== 1'b0) begin
            n_fail++;
            $display("FAIL periodic_first got pend=%b ovf=%b irq=%b want 1 0 0", ti_pending, ti_ovf, irq_ti);
        end
        tick();
        n_tests++;
        if (irq_ti !== 1'b1) begin
            n_fail++; $display("FAIL periodic_irq_lag got irq=%b want 1", irq_ti);
        end
        for (int i = 0; i < 15; i++) tick();
        pulse_intr();
        n_tests++;
        if (ti_pending !== 1'b1 || ti_ovf !== 1'b1) begin
            n_fail++; $display("FAIL periodic_second got pend=%b ovf=%b want 1 1", ti_pending, ti_ovf);
        end
    endtask

    task automatic test_clear_race();
        csr_we = 1; csr_waddr = A_TICLR; csr_wdata = 32'h1; timer_intr = 1;
        tick();
        csr_we = 0; csr_waddr = '0; csr_wdata = '0; timer_intr = 0;
        n_tests++;
        if (ti_pending !== 1'b1 || ti_ovf !== 1'b1) begin
            n_fail++; $display("FAIL clear_race got pend=%b ovf=%b want 1 1", ti_pending, ti_ovf);
        end
        wr(A_TICLR, 32'h3);
        n_tests++;
        if (ti_pending !== 1'b0 || ti_ovf !== 1'b0) begin
            n_fail++; $display("FAIL clear_quiet got pend=%b ovf=%b want 0 0", ti_pending, ti_ovf);
        end
        tick();
        n_tests++;
        if (irq_ti !== 1'b0) begin
            n_fail++; $display("FAIL clear_irq got irq=%b want 0", irq_ti);
        end
    endtask

    task automatic test_disable();
        wr(A_TCFG, 32'h0000_0010);
        n_tests++;
        if (timer_en !== 1'b0 || timer_init !== 1'b1) begin
            n_fail++; $display("FAIL disable_cfg got en=%b init=%b want 0 1", timer_en, timer_init);
        end
        tick();
        pulse_intr();
        tick();
        n_tests++;
        if (ti_pending !== 1'b0 || ti_ovf !== 1'b0) begin
            n_fail++; $display("FAIL disable_ignore got pend=%b ovf=%b want 0 0", ti_pending, ti_ovf);
        end
    endtask

    task automatic test_back_to_back();
        wr(A_TCFG, 32'h0000_0029);
        n_tests++;
        if (timer_init !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first got init=%b want 1", timer_init);
        end
        wr(A_TCFG, 32'h0000_0013);
        n_tests++;
        if (timer_init !== 1'b1 || timer_periodic !== 1'b1 || timer_initval !== 30'd4 || timer_en !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second got init=%b per=%b iv=%0d en=%b want 1 1 4 1",
                     timer_init, timer_periodic, timer_initval, timer_en);
        end
        tick();
        n_tests++;
        if (timer_init !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got init=%b want 0", timer_init);
        end
    endtask

    task automatic test_reads();
        logic [31:0] v;
        csr_raddr = A_TCFG;
        csr_we = 1; csr_waddr = A_TCFG; csr_wdata = 32'hABCD_1235;
        #1;
        n_tests++;
        if (csr_rdata !== 32'h0000_0013 || csr_rhit !== 1'b1) begin
            n_fail++; $display("FAIL read_tcfg_old got %h hit=%b want 00000013 1", csr_rdata, csr_rhit);
        end
        tick();
        csr_we = 0; csr_waddr = '0; csr_wdata = '0;
        n_tests++;
        if (csr_rdata !== 32'hABCD_1235) begin
            n_fail++; $display("FAIL read_tcfg_new got %h want abcd1235", csr_rdata);
        end
        wr(A_TVAL, 32'hFFFF_FFFF);
        n_tests++;
        if (csr_rdata !== 32'hABCD_1235 || timer_init !== 1'b0) begin
            n_fail++; $display("FAIL tval_write_ignored got tcfg=%h init=%b want abcd1235 0", csr_rdata, timer_init);
        end
        csr_raddr = A_TVAL;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            timer_val = v;
            #1;
            n_tests++;
            if (csr_rdata !== v || csr_rhit !== 1'b1) begin
                n_fail++; $display("FAIL read_tval got %h hit=%b want %h 1", csr_rdata, csr_rhit, v);
            end
        end
        csr_raddr = A_TICLR;
        #1;
        n_tests++;
        if (csr_rdata !== {30'b0, m_ovf, 1'b0} || csr_rdata[0] !== 1'b0) begin
            n_fail++; $display("FAIL read_ticlr got %h want %h", csr_rdata, {30'b0, m_ovf, 1'b0});
        end
        csr_raddr = A_NONE;
        #1;
        n_tests++;
        if (csr_rdata !== 32'h0 || csr_rhit !== 1'b0) begin
            n_fail++; $display("FAIL read_unmapped got %h hit=%b want 0 0", csr_rdata, csr_rhit);
        end
    endtask

    task automatic test_reset_arm();
        wr(A_TCFG, 32'h0000_0029);
        tick();
        pulse_intr();
        wr(A_TCFG, 32'h0000_0029);
        n_tests++;
        if (ti_pending !== 1'b1 || timer_init !== 1'b1) begin
            n_fail++; $display("FAIL reset_arm_setup got pend=%b init=%b want 1 1", ti_pending, timer_init);
        end
        resetn = 0;
        tick();
        n_tests++;
        if ({timer_init, timer_en, timer_periodic, timer_initval, ti_pending, ti_ovf, irq_ti} !== '0) begin
            n_fail++;
            $display("FAIL reset_arm got init=%b en=%b pend=%b ovf=%b irq=%b want all 0",
                     timer_init, timer_en, ti_pending, ti_ovf, irq_ti);
        end
        resetn = 1;
        tick();
        n_tests++;
        if (timer_init !== 1'b0 || timer_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_arm_after got init=%b en=%b want 0 0", timer_init, timer_en);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        logic        exp_hit;
        int          sel;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            resetn     = ($urandom_range(0, 299) != 0);
            sel        = $urandom_range(0, 9);
            csr_we     = (sel < 4);
            csr_waddr  = (sel == 0) ? A_TCFG : (sel == 1) ? A_TVAL : (sel == 2) ? A_NONE : A_TICLR;
            if (sel == 0 && $urandom_range(0, 2) != 0) csr_waddr = A_TICLR;
            csr_wdata  = $urandom;
            if (sel == 0 && $urandom_range(0, 3) == 0) csr_waddr = A_TCFG;
            timer_intr = ($urandom_range(0, 2) == 0);
            lie_ti     = $urandom_range(0, 1);
            timer_val  = $urandom;
            csr_raddr  = 14'h040 + 14'($urandom_range(0, 5));
            #1;
            exp_hit = 1;
            case (csr_raddr)
                A_TCFG:  exp_rd = {m_iv, m_per, m_en};
                A_TVAL:  exp_rd = timer_val;
                A_TICLR: exp_rd = {30'b0, m_ovf, 1'b0};
                default: begin exp_rd = 0; exp_hit = 0; end
            endcase
            n_tests++;
            if (csr_rdata !== exp_rd || csr_rhit !== exp_hit) begin
                n_fail++;
                $display("FAIL rand_read cyc=%0d addr=%h got %h/%b want %h/%b",
                         cyc, csr_raddr, csr_rdata, csr_rhit, exp_rd, exp_hit);
            end
            tick();
            n_tests++;
            if ({timer_init, timer_en, timer_periodic, timer_initval, ti_pending, ti_ovf, irq_ti} !==
                {m_init, m_en, m_per, m_iv, m_pend, m_ovf, m_irq}) begin
                n_fail++;
                $display("FAIL rand_state cyc=%0d got init=%b en=%b per=%b iv=%h pend=%b ovf=%b irq=%b want %b %b %b %h %b %b %b",
                         cyc, timer_init, timer_en, timer_periodic, timer_initval, ti_pending, ti_ovf, irq_ti,
                         m_init, m_en, m_per, m_iv, m_pend, m_ovf, m_irq);
            end
        end
        csr_we = 0; timer_intr = 0; resetn = 1;
    endtask

    initial begin
        m_en = 0; m_per = 0; m_iv = '0; m_init = 0;
        m_pend = 0; m_ovf = 0; m_irq = 0; m_done = 0; m_since = 0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_clear_race();
        test_disable();
        test_back_to_back();
        test_reads();
        test_reset_arm();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
